// File: rtl/psc_pkg.sv
// Shared types for the program sequencer / data-memory checker.
package psc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ARM,
        WAIT_ACK,
        SCAN,
        DONE
    } psc_state_t;

    // Index width that stays at least one bit for single-program builds.
    function automatic int psc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psc_range_scanner.sv
// Walks one inclusive address range, one read per cycle, and compares the
// two memories' read data one cycle later.
module psc_range_scanner
    import psc_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    input  logic [DW-1:0] dm_data,
    input  logic [DW-1:0] gold_data,
    output logic [AW-1:0] addr,
    output logic          busy,
    output logic          mismatch,
    output logic [AW-1:0] mis_addr
);

    logic          vld_d;
    logic [AW-1:0] addr_d;

    // busy covers the issue phase only; the owner treats !busy as the last
    // cycle, which is also the cycle carrying the final compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr   <= '0;
            busy   <= 1'b0;
            vld_d  <= 1'b0;
            addr_d <= '0;
        end else begin
            vld_d  <= busy;
            addr_d <= addr;
            if (go) begin
                addr <= lo;
                busy <= (lo <= hi);
            end else if (busy) begin
                // Stop on hi instead of incrementing, so hi == all-ones cannot wrap.
                if (addr == hi) busy <= 1'b0;
                else            addr <= addr + 1'b1;
            end
        end
    end

    assign mismatch = vld_d && (dm_data != gold_data);
    assign mis_addr = addr_d;

endmodule

// File: rtl/prog_seq_checker.sv
// Multi-program run sequencer with golden data-memory compare.
// Optional watchdog on the Start/Ack handshake: define PSC_TIMEOUT_EN.
module prog_seq_checker
    import psc_pkg::*;
#(
    parameter int NUM_PROGS = 3,
    parameter int DW        = 8,
    parameter int AW        = 8,
    parameter int ECW       = 8,
    parameter int TO_W      = 16
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 Go,
    input  logic [NUM_PROGS*AW-1:0]              RangeLo,
    input  logic [NUM_PROGS*AW-1:0]              RangeHi,
    output logic                                 DutStart,
    input  logic                                 DutAck,
    output logic [AW-1:0]                        DmAddr,
    input  logic [DW-1:0]                        DmData,
    input  logic [DW-1:0]                        GoldData,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 Pass,
    output logic [psc_idx_w(NUM_PROGS)-1:0]      ProgIdx,
    output logic [ECW-1:0]                       ErrCount,
    output logic [AW-1:0]                        FirstErrAddr,
    output logic [psc_idx_w(NUM_PROGS)-1:0]      FirstErrProg,
    output logic                                 TimeoutFlag
);

    localparam int PW = psc_idx_w(NUM_PROGS);

    psc_state_t    state;
    logic [AW-1:0] prog_lo;
    logic [AW-1:0] prog_hi;
    logic          scan_go;
    logic          scan_busy;
    logic          mismatch;
    logic [AW-1:0] mis_addr;
    logic          err_inc;
    logic          wd_fire;
    logic          prog_end;
    logic          last_prog;
    logic          launch;

    assign prog_lo   = RangeLo[int'(ProgIdx)*AW +: AW];
    assign prog_hi   = RangeHi[int'(ProgIdx)*AW +: AW];
    assign launch    = ((state == IDLE) || (state == DONE)) && Go;
    assign scan_go   = (state == WAIT_ACK) && DutAck;
    assign err_inc   = (state == SCAN) && mismatch;
    assign last_prog = (ProgIdx == PW'(NUM_PROGS - 1));
    assign prog_end  = ((state == SCAN) && !scan_busy) || wd_fire;

    psc_range_scanner #(
        .DW (DW),
        .AW (AW)
    ) u_scan (
        .clk       (Clk),
        .rst_n     (Reset),
        .go        (scan_go),
        .lo        (prog_lo),
        .hi        (prog_hi),
        .dm_data   (DmData),
        .gold_data (GoldData),
        .addr      (DmAddr),
        .busy      (scan_busy),
        .mismatch  (mismatch),
        .mis_addr  (mis_addr)
    );

`ifdef PSC_TIMEOUT_EN
    logic [TO_W-1:0] wd;
    logic            to_flag;

    // A real Ack arriving on the expiry cycle still wins.
    assign wd_fire = ((state == ARM) || ((state == WAIT_ACK) && !DutAck)) && (wd == '1);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wd      <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == START)                            wd <= '0;
            else if ((state == ARM) || (state == WAIT_ACK)) wd <= wd + 1'b1;
            if (launch)       to_flag <= 1'b0;
            else if (wd_fire) to_flag <= 1'b1;
        end
    end

    assign TimeoutFlag = to_flag;
`else
    localparam int unused_to_w = TO_W;
    assign wd_fire     = 1'b0;
    assign TimeoutFlag = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= IDLE;
            DutStart     <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Pass         <= 1'b0;
            ProgIdx      <= '0;
            ErrCount     <= '0;
            FirstErrAddr <= '0;
            FirstErrProg <= '0;
        end else begin
            DutStart <= 1'b0;

            if (err_inc) begin
                if (ErrCount != '1) ErrCount <= ErrCount + 1'b1;
                // Saturated count never returns to zero, so zero marks "no error yet".
                if (ErrCount == '0) begin
                    FirstErrAddr <= mis_addr;
                    FirstErrProg <= ProgIdx;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (Go) begin
                        ErrCount     <= '0;
                        FirstErrAddr <= '0;
                        FirstErrProg <= '0;
                        Pass         <= 1'b0;
                        Done         <= 1'b0;
                        ProgIdx      <= '0;
                        Busy         <= 1'b1;
                        DutStart     <= 1'b1;
                        state        <= START;
                    end
                end
                START:    state <= ARM;
                ARM:      if (!DutAck) state <= WAIT_ACK;
                WAIT_ACK: if (DutAck)  state <= SCAN;
                SCAN:     ;
                default:  state <= IDLE;
            endcase

            // End of a program, either by finished scan or by watchdog skip.
            if (prog_end) begin
                if (last_prog) begin
                    state <= DONE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    Pass  <= (ErrCount == '0) && !err_inc && !TimeoutFlag && !wd_fire;
                end else begin
                    ProgIdx  <= ProgIdx + 1'b1;
                    DutStart <= 1'b1;
                    state    <= START;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_seq_checker.sv
// Directed bench: Ack-driven DUT model plus 1-cycle-latency DM and golden memories.
module tb_prog_seq_checker;

    localparam int NP   = 3;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int ECW  = 8;
    localparam int TO_W = 4;
`ifdef PSC_TIMEOUT_EN
    localparam int ACK_RISE = 12;
`else
    localparam int ACK_RISE = 20;
`endif

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Go;
    logic [NP*AW-1:0]  RangeLo;
    logic [NP*AW-1:0]  RangeHi;
    logic              DutStart;
    logic              DutAck = 1'b0;
    logic [AW-1:0]     DmAddr;
    logic [DW-1:0]     DmData;
    logic [DW-1:0]     GoldData;
    logic              Busy;
    logic              Done;
    logic              Pass;
    logic [1:0]        ProgIdx;
    logic [ECW-1:0]    ErrCount;
    logic [AW-1:0]     FirstErrAddr;
    logic [1:0]        FirstErrProg;
    logic              TimeoutFlag;

    int checks = 0;
    int errors = 0;

    prog_seq_checker #(
        .NUM_PROGS (NP),
        .DW        (DW),
        .AW        (AW),
        .ECW       (ECW),
        .TO_W      (TO_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Go           (Go),
        .RangeLo      (RangeLo),
        .RangeHi      (RangeHi),
        .DutStart     (DutStart),
        .DutAck       (DutAck),
        .DmAddr       (DmAddr),
        .DmData       (DmData),
        .GoldData     (GoldData),
        .Busy         (Busy),
        .Done         (Done),
        .Pass         (Pass),
        .ProgIdx      (ProgIdx),
        .ErrCount     (ErrCount),
        .FirstErrAddr (FirstErrAddr),
        .FirstErrProg (FirstErrProg),
        .TimeoutFlag  (TimeoutFlag)
    );

    always #5 Clk = ~Clk;

    logic [DW-1:0] dm   [256];
    logic [DW-1:0] gold [256];

    always @(posedge Clk) begin
        DmData   <= dm[DmAddr];
        GoldData <= gold[DmAddr];
    end

    // DUT model: Ack drops drop_at cycles after Start, rises at rise_at.
    int drop_at     = 1;
    int rise_at     = ACK_RISE;
    int no_ack_prog = -1;
    int ack_cnt     = 0;
    bit ack_run     = 0;
    bit ack_rose    = 0;

    always @(posedge Clk) begin
        if (!Reset) begin
            ack_run = 0;
        end else if (DutStart) begin
            ack_run  = 1;
            ack_cnt  = 0;
            ack_rose = 0;
        end else if (ack_run) begin
            ack_cnt++;
            if (ack_cnt == drop_at) DutAck <= 1'b0;
            if (ack_cnt == rise_at && int'(ProgIdx) != no_ack_prog) begin
                DutAck   <= 1'b1;
                ack_rose = 1;
                ack_run  = 0;
            end
        end
    end

    int cmp_cnt [NP];
    int early_cmp = 0;
    int starts    = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            if (dut.u_scan.vld_d) begin
                cmp_cnt[int'(ProgIdx)]++;
                if (!ack_rose) early_cmp++;
            end
            if (DutStart) starts++;
        end
    end

    task automatic clear_counts();
        for (int p = 0; p < NP; p++) cmp_cnt[p] = 0;
        early_cmp = 0;
        starts    = 0;
    endtask

    task automatic set_range(input int p, input int lo, input int hi);
        RangeLo[p*AW +: AW] = AW'(lo);
        RangeHi[p*AW +: AW] = AW'(hi);
    endtask

    task automatic default_ranges();
        set_range(0, 30, 59);
        set_range(1, 94, 123);
        set_range(2, 192, 194);
    endtask

    task automatic restore_mem();
        for (int i = 0; i < 256; i++) begin
            gold[i] = 8'(i * 7 + 3);
            dm[i]   = gold[i];
        end
    endtask

    task automatic pulse_go();
        @(negedge Clk); Go = 1'b1;
        @(negedge Clk); Go = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!Done && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (Done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: Done=%b after %0d cycles, want 1", nm, Done, n);
        end
    endtask

    task automatic check_cmps(input string nm, input int c0, input int c1, input int c2);
        checks++;
        if (cmp_cnt[0] != c0 || cmp_cnt[1] != c1 || cmp_cnt[2] != c2) begin
            errors++;
            $display("FAIL %s_cmps: got %0d/%0d/%0d want %0d/%0d/%0d",
                     nm, cmp_cnt[0], cmp_cnt[1], cmp_cnt[2], c0, c1, c2);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({DutStart, Busy, Done, Pass, ProgIdx, ErrCount, FirstErrAddr, FirstErrProg,
             TimeoutFlag, DmAddr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: Busy=%b Done=%b Pass=%b Err=%0d DmAddr=%0d, want all 0",
                     Busy, Done, Pass, ErrCount, DmAddr);
        end
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_clean();
        clear_counts();
        pulse_go();
        checks++;
        if (Busy !== 1'b1 || ProgIdx !== 2'd0) begin
            errors++;
            $display("FAIL clean_launch: Busy=%b ProgIdx=%0d want 1/0", Busy, ProgIdx);
        end
        wait_done("clean");
        checks++;
        if (starts != 3) begin
            errors++;
            $display("FAIL clean_starts: got %0d want 3", starts);
        end
        checks++;
        if (Pass !== 1'b1 || ErrCount !== 8'd0 || Busy !== 1'b0 || TimeoutFlag !== 1'b0) begin
            errors++;
            $display("FAIL clean_result: Pass=%b Err=%0d Busy=%b TO=%b want 1/0/0/0",
                     Pass, ErrCount, Busy, TimeoutFlag);
        end
        check_cmps("clean", 30, 30, 3);
        repeat (3) @(negedge Clk);
        checks++;
        if (Done !== 1'b1 || Pass !== 1'b1) begin
            errors++;
            $display("FAIL clean_hold: Done=%b Pass=%b want 1/1", Done, Pass);
        end
    endtask

    task automatic test_mismatch();
        restore_mem();
        dm[40]  = dm[40] ^ 8'h01;
        dm[100] = dm[100] ^ 8'h80;
        clear_counts();
        pulse_go();
        wait_done("mis");
        checks++;
        if (ErrCount !== 8'd2 || FirstErrAddr !== 8'd40 || FirstErrProg !== 2'd0 || Pass !== 1'b0) begin
            errors++;
            $display("FAIL mis_result: Err=%0d First=%0d/%0d Pass=%b want 2 40/0 0",
                     ErrCount, FirstErrAddr, FirstErrProg, Pass);
        end
        restore_mem();
    endtask

    task automatic test_edge_ranges();
        set_range(1, 77, 77);
        set_range(2, 200, 199);
        dm[77] = ~gold[77];
        clear_counts();
        pulse_go();
        wait_done("edge");
        check_cmps("edge", 30, 1, 0);
        checks++;
        if (ErrCount !== 8'd1 || FirstErrAddr !== 8'd77 || FirstErrProg !== 2'd1 || Pass !== 1'b0) begin
            errors++;
            $display("FAIL edge_result: Err=%0d First=%0d/%0d Pass=%b want 1 77/1 0",
                     ErrCount, FirstErrAddr, FirstErrProg, Pass);
        end
        restore_mem();
        default_ranges();
    endtask

    task automatic test_top_addr();
        set_range(0, 0, 0);
        set_range(1, 250, 255);
        set_range(2, 255, 255);
        dm[251] = ~gold[251];
        dm[255] = ~gold[255];
        clear_counts();
        pulse_go();
        wait_done("top");
        check_cmps("top", 1, 6, 1);
        checks++;
        if (ErrCount !== 8'd3 || FirstErrAddr !== 8'd251 || FirstErrProg !== 2'd1) begin
            errors++;
            $display("FAIL top_result: Err=%0d First=%0d/%0d want 3 251/1",
                     ErrCount, FirstErrAddr, FirstErrProg);
        end
        restore_mem();
        default_ranges();
    endtask

    task automatic test_saturation();
        set_range(0, 0, 255);
        set_range(1, 10, 9);
        set_range(2, 5, 4);
        for (int i = 0; i < 256; i++) dm[i] = ~gold[i];
        clear_counts();
        pulse_go();
        wait_done("sat");
        check_cmps("sat", 256, 0, 0);
        checks++;
        if (ErrCount !== 8'd255 || FirstErrAddr !== 8'd0 || Pass !== 1'b0) begin
            errors++;
            $display("FAIL sat_result: Err=%0d First=%0d Pass=%b want 255 0 0",
                     ErrCount, FirstErrAddr, Pass);
        end
        restore_mem();
        default_ranges();
    endtask

    task automatic test_stale_ack();
        checks++;
        if (DutAck !== 1'b1) begin
            errors++;
            $display("FAIL stale_pre: DutAck=%b want 1 before run", DutAck);
        end
        drop_at = 3;
        rise_at = 13;
        clear_counts();
        pulse_go();
        wait_done("stale");
        checks++;
        if (early_cmp != 0) begin
            errors++;
            $display("FAIL stale_early: %0d compares before Ack rise, want 0", early_cmp);
        end
        check_cmps("stale", 30, 30, 3);
        checks++;
        if (ErrCount !== 8'd0 || Pass !== 1'b1) begin
            errors++;
            $display("FAIL stale_result: Err=%0d Pass=%b want 0/1", ErrCount, Pass);
        end
        drop_at = 1;
        rise_at = ACK_RISE;
    endtask

    task automatic test_go_while_busy();
        clear_counts();
        pulse_go();
        repeat (10) @(negedge Clk);
        pulse_go();
        wait_done("busy_go");
        checks++;
        if (starts != 3 || Pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_go: starts=%0d Pass=%b want 3/1", starts, Pass);
        end
    endtask

`ifdef PSC_TIMEOUT_EN
    task automatic test_timeout();
        no_ack_prog = 1;
        clear_counts();
        pulse_go();
        wait_done("to");
        checks++;
        if (TimeoutFlag !== 1'b1 || Pass !== 1'b0 || starts != 3) begin
            errors++;
            $display("FAIL to_result: TO=%b Pass=%b starts=%0d want 1/0/3", TimeoutFlag, Pass, starts);
        end
        check_cmps("to", 30, 0, 3);
        no_ack_prog = -1;
    endtask
`endif

    task automatic test_reset_mid();
        int n = 0;
        dm[40] = ~gold[40];
        clear_counts();
        pulse_go();
        while (!(ProgIdx == 2'd1 && dut.u_scan.busy) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (ProgIdx !== 2'd1) begin
            errors++;
            $display("FAIL rmid_reach: ProgIdx=%0d want 1 (prog1 scan never seen)", ProgIdx);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if ({DutStart, Busy, Done, Pass, ProgIdx, ErrCount, FirstErrAddr, FirstErrProg,
             TimeoutFlag, DmAddr} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs: Busy=%b ProgIdx=%0d Err=%0d DmAddr=%0d want all 0",
                     Busy, ProgIdx, ErrCount, DmAddr);
        end
        Reset = 1'b1;
        @(negedge Clk);
        clear_counts();
        pulse_go();
        checks++;
        if (ProgIdx !== 2'd0 || ErrCount !== 8'd0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_rerun: ProgIdx=%0d Err=%0d Busy=%b want 0/0/1", ProgIdx, ErrCount, Busy);
        end
        wait_done("rmid");
        checks++;
        if (ErrCount !== 8'd1 || FirstErrAddr !== 8'd40 || starts != 3) begin
            errors++;
            $display("FAIL rmid_result: Err=%0d First=%0d starts=%0d want 1 40 3",
                     ErrCount, FirstErrAddr, starts);
        end
        restore_mem();
    endtask

    initial begin
        Reset = 1'b0;
        Go    = 1'b0;
        default_ranges();
        restore_mem();
        test_reset();
        test_clean();
        test_mismatch();
        test_edge_ranges();
        test_top_addr();
        test_saturation();
        test_stale_ack();
        test_go_while_busy();
`ifdef PSC_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
